c17_bist_driver: RTL and testbench
==================================

# c17_bist_driver

Built-in self-test driver for the c17 combinational core. It generates pseudo-random input vectors with a 5-bit LFSR and drives them onto the c17 primary inputs. It also compacts the two c17 primary outputs into an 8-bit MISR signature and compares that signature against a golden value. It sits on the opposite side of the c17 pin boundary: its outputs are c17's inputs, and its inputs are c17's outputs.

## Interface

Parameters:
- NUM_PATTERNS, 31: number of vectors applied per run. Legal range is 1..31.
- SEED, 5'b00001: LFSR start value. A value of 0 is illegal and is replaced by 5'b00001.
- GOLDEN, 8'h00: expected MISR signature after the final vector.

Ports:
- blif_clk_net  in  1  single clock. All state changes on its rising edge.
- blif_reset_net  in  1  synchronous reset, active-high.
- start  in  1  run request, sampled at the clock edge.
- nx22  in  1  c17 output; response bit 0.
- nx23  in  1  c17 output; response bit 1.
- nx1  out  1  c17 input, driven from pat[4].
- nx2  out  1  c17 input, driven from pat[3].
- nx3  out  1  c17 input, driven from pat[2].
- nx6  out  1  c17 input, driven from pat[1].
- nx7  out  1  c17 input, driven from pat[0].
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE.
- pass  out  1  result of the signature compare. Valid only while done is high.
- sig  out  8  MISR contents.

## Operation

- Only the clock and reset decisions are fixed: one clock; reset is synchronous and active-high.
- State machine states: IDLE, RUN, CHECK, DONE.
- IDLE
  - All PI outputs are 0.
  - If start=1, go to RUN with pat<=SEED, cnt<=0, misr<=0, busy<=1.
- RUN, at each edge:
  - misr <= {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ {6'b0, nx23, nx22}.
  - cnt <= cnt+1.
  - pat <= {pat[3:0], pat[4]^pat[2]}. This is x^5+x^3+1, period 31.
  - If cnt==NUM_PATTERNS-1: go to CHECK and drive all PIs to 0.
- CHECK, one cycle:
  - Go to DONE with done<=1, busy<=0, pass<=(misr==GOLDEN).
- DONE
  - Outputs hold.
  - start=1 restarts exactly as from IDLE, and done and pass clear on that edge.
- start is ignored in RUN and CHECK.
- PI outputs are registered straight from pat, with no combinational path from any input.
- c17 is purely combinational. The response to vector k is therefore sampled at the same edge that ends vector k.
- cnt is 5 bits wide and never wraps, because NUM_PATTERNS ≤ 31.
- sig always shows misr. It is meaningful once done=1.

## Timing

- Reset values: every output is 0 (nx1..nx7, busy, done, pass, sig). State is IDLE, pat=0, cnt=0, misr=0.
- Reset has priority over everything, including start on the same edge. Reset during a run returns the block to IDLE on that edge; no partial result is reported.
- Edge E0 samples start=1. Vector 0 is on the PIs from E0 until E1, and vector k from Ek until Ek+1.
- Edge E_N captures the final response. The block is in CHECK between E_N and E_{N+1}, where N = NUM_PATTERNS.
- done and pass rise after E_{N+1}. Start-to-done latency is N+1 edges after E0.
- busy is high from after E0 until E_{N+1}.
- With NUM_PATTERNS=1, the block goes RUN→CHECK after a single edge.

## Test plan

- Reset: hold blif_reset_net high for 2 cycles with start=1.
  - Required: all outputs 0 and busy never asserts.
- Single vector: NUM_PATTERNS=1, GOLDEN=8'h02, start pulse.
  - After E0: nx7=1, nx1=nx2=nx3=nx6=0, and the c17 model gives nx22=0, nx23=1.
  - After E1: sig=8'h02.
  - After E2: done=1, pass=1, busy=0.
- LFSR sequence: NUM_PATTERNS=6.
  - Required: {nx1,nx2,nx3,nx6,nx7} = 00001, 00010, 00100, 01001, 10010, 00101 on consecutive cycles, then 00000 in CHECK.
- Full run: NUM_PATTERNS=31, GOLDEN=8'h00, with the c17 gate model attached.
  - Required: 31 distinct nonzero vectors, and done 32 edges after E0.
  - sig must equal the bench's MISR reference model.
  - pass=0 unless the reference signature is 8'h00.
- Abuse:
  - Start held high throughout RUN: the sequence is unaffected.
  - Reset at RUN cycle 3: all outputs are 0 after that edge, and a subsequent start reproduces the vector sequence from SEED.
- Restart from DONE: a start pulse clears done and pass on the same edge, and the second run gives an identical sig.

Source files
------------

// File: rtl/c17_bist_driver_if.sv
// Pin bundle between the BIST driver and the c17 core plus its run/status signals.
// master is the driver side; slave is the c17 / test-controller side.
interface c17_bist_driver_if;
   logic       start;
   logic       nx22;
   logic       nx23;
   logic       nx1;
   logic       nx2;
   logic       nx3;
   logic       nx6;
   logic       nx7;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] sig;

   modport master (
      input  start, nx22, nx23,
      output nx1, nx2, nx3, nx6, nx7, busy, done, pass, sig
   );

   modport slave (
      output start, nx22, nx23,
      input  nx1, nx2, nx3, nx6, nx7, busy, done, pass, sig
   );
endinterface

// File: rtl/c17_bist_driver.sv
// BIST driver for c17: 5-bit LFSR pattern source, 8-bit MISR response compactor,
// and a golden-signature compare at the end of each run.
module c17_bist_driver #(
   parameter int unsigned NUM_PATTERNS = 31,
   parameter logic [4:0]  SEED         = 5'b00001,
   parameter logic [7:0]  GOLDEN       = 8'h00
) (
   input logic               blif_clk_net,
   input logic               blif_reset_net,
   c17_bist_driver_if.master bus
);

   // An all-zero seed would lock the LFSR up, so fall back to 1.
   localparam logic [4:0] SeedEff = (SEED == 5'd0) ? 5'b00001 : SEED;
   localparam logic [4:0] LastCnt = 5'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

   state_e     state_q, state_d;
   logic [4:0] pat_q, pat_d;
   logic [4:0] cnt_q, cnt_d;
   logic [4:0] pi_q, pi_d;
   logic [7:0] misr_q, misr_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [4:0] pat_next;

   assign pat_next = {pat_q[3:0], pat_q[4] ^ pat_q[2]};

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      pi_d    = pi_q;
      misr_d  = misr_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StRun;
               pat_d   = SeedEff;
               pi_d    = SeedEff;
               cnt_d   = 5'd0;
               misr_d  = 8'h00;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         StRun: begin
            // c17 is combinational, so this edge captures the response to the current vector.
            misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]}
                     ^ {6'b0, bus.nx23, bus.nx22};
            cnt_d  = cnt_q + 5'd1;
            pat_d  = pat_next;
            pi_d   = pat_next;
            if (cnt_q == LastCnt) begin
               state_d = StCheck;
               pi_d    = 5'd0;
            end
         end
         StCheck: begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (misr_q == GOLDEN);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         state_q <= StIdle;
         pat_q   <= 5'd0;
         cnt_q   <= 5'd0;
         pi_q    <= 5'd0;
         misr_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         pi_q    <= pi_d;
         misr_q  <= misr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.nx1  = pi_q[4];
   assign bus.nx2  = pi_q[3];
   assign bus.nx3  = pi_q[2];
   assign bus.nx6  = pi_q[1];
   assign bus.nx7  = pi_q[0];
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.pass = pass_q;
   assign bus.sig  = misr_q;

endmodule

// File: tb/tb_c17_bist_driver.sv
// Bench for c17_bist_driver: three instances (1, 6 and 31 patterns), each with a c17 gate model,
// checked against a bench-side LFSR/MISR reference through an expected-vector queue.
module tb_c17_bist_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_all = 1'b0;
   logic [1:0] sel = 2'd0;
   int         n_checks = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   c17_bist_driver_if bus0 ();
   c17_bist_driver_if bus1 ();
   c17_bist_driver_if bus2 ();

   c17_bist_driver #(.NUM_PATTERNS(1), .SEED(5'b00001), .GOLDEN(8'h02)) dut0 (
      .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus0));
   // Zero seed exercises the fallback to 5'b00001.
   c17_bist_driver #(.NUM_PATTERNS(6), .SEED(5'b00000), .GOLDEN(8'h00)) dut1 (
      .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus1));
   c17_bist_driver #(.NUM_PATTERNS(31), .SEED(5'b00001), .GOLDEN(8'h00)) dut2 (
      .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus2));

   // Returns {nx23, nx22} for v = {nx1, nx2, nx3, nx6, nx7}.
   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      {n1, n2, n3, n6, n7} = v;
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n16 & n19), ~(n10 & n16)};
   endfunction

   function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [1:0] r);
      return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {6'b0, r};
   endfunction

   function automatic logic [7:0] golden_of(input logic [1:0] s);
      return (s == 2'd0) ? 8'h02 : 8'h00;
   endfunction

   logic [4:0] pi_a  [3];
   logic [2:0] st_a  [3];
   logic [7:0] sig_a [3];
   logic [1:0] resp_a[3];

   assign pi_a[0] = {bus0.nx1, bus0.nx2, bus0.nx3, bus0.nx6, bus0.nx7};
   assign pi_a[1] = {bus1.nx1, bus1.nx2, bus1.nx3, bus1.nx6, bus1.nx7};
   assign pi_a[2] = {bus2.nx1, bus2.nx2, bus2.nx3, bus2.nx6, bus2.nx7};
   assign st_a[0] = {bus0.busy, bus0.done, bus0.pass};
   assign st_a[1] = {bus1.busy, bus1.done, bus1.pass};
   assign st_a[2] = {bus2.busy, bus2.done, bus2.pass};
   assign sig_a[0] = bus0.sig;
   assign sig_a[1] = bus1.sig;
   assign sig_a[2] = bus2.sig;
   assign resp_a[0] = c17(pi_a[0]);
   assign resp_a[1] = c17(pi_a[1]);
   assign resp_a[2] = c17(pi_a[2]);
   assign {bus0.nx23, bus0.nx22} = resp_a[0];
   assign {bus1.nx23, bus1.nx22} = resp_a[1];
   assign {bus2.nx23, bus2.nx22} = resp_a[2];
   assign bus0.start = start_all | (start & (sel == 2'd0));
   assign bus1.start = start_all | (start & (sel == 2'd1));
   assign bus2.start = start_all | (start & (sel == 2'd2));

   logic [4:0] obs_pi;
   logic [2:0] obs_st;
   logic [7:0] obs_sig;
   logic [1:0] obs_resp;

   always_comb begin
      obs_pi   = pi_a[sel];
      obs_st   = st_a[sel];
      obs_sig  = sig_a[sel];
      obs_resp = resp_a[sel];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_all = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            rst = 1'b0;
            start_all = 1'b0;
         end
         tick();
         for (int s = 0; s < 3; s++) begin
            n_checks++;
            if ({pi_a[s], st_a[s], sig_a[s]} !== 16'h0000)
               $display("FAIL reset dut%0d cycle%0d: pi=%b st=%b sig=%h, want all 0",
                        s, c, pi_a[s], st_a[s], sig_a[s]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_single();
      sel = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (obs_pi !== 5'b00001) $display("FAIL single_vec: got %b want 00001", obs_pi);
      else n_pass++;
      n_checks++;
      if (obs_resp !== 2'b10) $display("FAIL single_resp: got %b want 10", obs_resp);
      else n_pass++;
      n_checks++;
      if (obs_st !== 3'b100) $display("FAIL single_run_st: got %b want 100", obs_st);
      else n_pass++;
      tick();
      n_checks++;
      if (obs_sig !== 8'h02) $display("FAIL single_sig: got %h want 02", obs_sig);
      else n_pass++;
      n_checks++;
      if ({obs_pi, obs_st} !== 8'b00000_100)
         $display("FAIL single_check: pi=%b st=%b want 00000 100", obs_pi, obs_st);
      else n_pass++;
      tick();
      n_checks++;
      if (obs_st !== 3'b011) $display("FAIL single_done: got %b want 011", obs_st);
      else n_pass++;
   endtask

   task automatic run_seq(input logic [1:0] s, input int n, input bit hold,
                          output logic [7:0] sig_out);
      logic [4:0] exp_q[$];
      logic [4:0] p;
      logic [4:0] v;
      logic [7:0] m;
      logic [31:0] seen;
      p = 5'b00001;
      m = 8'h00;
      seen = '0;
      sel = s;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(p);
         m = misr_step(m, c17(p));
         p = {p[3:0], p[4] ^ p[2]};
      end
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int k = 0; k < n; k++) begin
         v = exp_q.pop_front();
         n_checks++;
         if (obs_pi !== v) $display("FAIL vec dut%0d k%0d: got %b want %b", s, k, obs_pi, v);
         else n_pass++;
         n_checks++;
         if (obs_st !== 3'b100) $display("FAIL run_st dut%0d k%0d: got %b want 100", s, k, obs_st);
         else n_pass++;
         n_checks++;
         if (obs_pi === 5'd0 || seen[obs_pi] === 1'b1)
            $display("FAIL distinct dut%0d k%0d: vector %b zero or repeated", s, k, obs_pi);
         else n_pass++;
         seen[obs_pi] = 1'b1;
         tick();
      end
      start = 1'b0;
      n_checks++;
      if ({obs_pi, obs_st, obs_sig} !== {5'd0, 3'b100, m})
         $display("FAIL check_st dut%0d: pi=%b st=%b sig=%h want 00000 100 %h",
                  s, obs_pi, obs_st, obs_sig, m);
      else n_pass++;
      tick();
      n_checks++;
      if ({obs_st, obs_sig} !== {2'b01, (m == golden_of(s)), m})
         $display("FAIL done dut%0d: st=%b sig=%h want 01%b %h",
                  s, obs_st, obs_sig, (m == golden_of(s)), m);
      else n_pass++;
      sig_out = obs_sig;
   endtask

   task automatic test_reset_midrun();
      logic [7:0] sg;
      sel = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({obs_pi, obs_st, obs_sig} !== 16'h0000)
         $display("FAIL midrun_reset: pi=%b st=%b sig=%h want all 0", obs_pi, obs_st, obs_sig);
      else n_pass++;
      run_seq(2'd2, 31, 1'b0, sg);
   endtask

   task automatic test_restart();
      logic [7:0] s1;
      logic [7:0] s2;
      run_seq(2'd0, 1, 1'b0, s1);
      run_seq(2'd0, 1, 1'b0, s2);
      run_seq(2'd2, 31, 1'b0, s1);
      run_seq(2'd2, 31, 1'b0, s2);
      n_checks++;
      if (s2 !== s1) $display("FAIL restart_sig: got %h want %h", s2, s1);
      else n_pass++;
   endtask

   initial begin
      logic [7:0] sg;
      test_reset();
      test_single();
      run_seq(2'd1, 6, 1'b0, sg);
      run_seq(2'd2, 31, 1'b0, sg);
      run_seq(2'd1, 6, 1'b1, sg);
      test_reset_midrun();
      test_restart();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
